control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives every DataPath strobe. Sequences fetch (T0-T2) and per-opcode execute steps (T3-T7).
//  Sits directly upstream of DataPath: consumes the IR contents and memory readiness, and replaces bench-driven control.
//  Adds a memory-wait handshake and a stall timeout that halts the CPU.
// PARAMETERS
//  IR_W        32  instruction width; opcode = ir[IR_W-1 -: 5]
//  TIMEOUT     15  max cycles a read state may wait for mem_ready before error halt
// PORTS
//  clock       in   1   system clock, all state on rising edge
//  clear       in   1   asynchronous, active-low reset
//  ir          in   IR_W  IR register output, stable from T3 until next T2
//  mem_ready   in   1   memory has data valid / write accepted
//  Gra,Grb,Grc out  1   register-select strobes to select/encode logic
//  Rin,Rout,BAout out 1 register file in / out / base-address out
//  PCout,PCin,IncPC out 1 program counter control
//  MARin,MDRin,MDRout out 1 memory address/data register control
//  IRin,Yin,Zin out 1   IR, Y, Z load enables
//  Zlowout,Zhighout out 1  Z halves onto bus
//  HIin,LOin   out  1   HI/LO load enables
//  Cout        out  1   sign-extended immediate onto bus
//  read        out  1   memory read request (MDR loads from memory)
//  mem_write   out  1   memory write strobe
//  alu_op      out  5   ALU opcode; 5'b00000 (ADD) when no ALU op active
//  run         out  1   1 while sequencing; 0 in HALT
//  error       out  1   sticky; set on memory timeout
// BEHAVIOUR
//  Reset (clear=0, any time): state=RST, all outputs 0 (run=0), wait counter=0, error=0. Aborts any instruction mid-flight.
//  RST->T0 on the first clock after release. Outputs are Moore: decoded from the state register and ir[31:27].
//  Opcodes: ADD 00000, SUB 00001, AND 00010, OR 00011, ADDI 00100, ANDI 00101, ORI 00110, MUL 00111, DIV 01000,
//    LD 01001, ST 01010, NOP 11010, HALT 11011. Any other opcode executes as NOP.
//  Fetch:
//    T0: PCout MARin IncPC Zin
//    T1: Zlowout PCin read MDRin. Holds while mem_ready=0; PCin is asserted only in the exit cycle.
//    T2: MDRout IRin
//  Execute (each step is 1 cycle; the last step returns to T0):
//    R-type ADD/SUB/AND/OR: T3 Grb Rout Yin | T4 Grc Rout alu_op Zin | T5 Zlowout Gra Rin
//    Imm ADDI/ANDI/ORI: T3 Grb Rout Yin | T4 Cout alu_op Zin | T5 Zlowout Gra Rin
//    MUL/DIV: T3 Gra Rout Yin | T4 Grb Rout alu_op Zin | T5 Zlowout LOin | T6 Zhighout HIin
//    LD: T3 Grb BAout Yin | T4 Cout alu_op=ADD Zin | T5 Zlowout MARin | T6 read MDRin (waits on mem_ready) | T7 MDRout Gra Rin
//    ST: T3 Grb BAout Yin | T4 Cout alu_op=ADD Zin | T5 Zlowout MARin | T6 Gra Rout MDRin | T7 mem_write (waits on mem_ready)
//    NOP: T3 (no strobes) -> T0. HALT: T3 -> HLT.
//  HLT: all strobes 0, run=0. Leave only by reset.
//  Wait states (T1, LD-T6, ST-T7):
//    - counter increments each stalled cycle and clears on exit.
//    - If the counter reaches TIMEOUT with mem_ready still 0: go to HLT, set error.
//    - mem_ready=1 in the same cycle the timeout is reached: the exit wins and error stays 0.
//  Combined latency with mem_ready tied 1: R-type/Imm 6 cycles, MUL/DIV 7, LD/ST 8, NOP 4.
// STRUCTURE
//  Shared package cpu_pkg:
//    - opcode localparams
//    - state encoding (RST, T0-T7, HLT; 4 bits)
//    - ALU_ADD constant
//  One sub-module: ctl_decode, the combinational map {state, opcode} -> strobe vector.
//  The top holds the state register, wait counter and error flag.
// TESTING
//  1. ORI R5,R2,0x0F, mem_ready=1: T3 Grb+Rout+Yin; T4 Cout+Zin, alu_op=00110; T5 Zlowout+Gra+Rin; T0 at cycle 7.
//  2. Fetch with mem_ready low 3 cycles: T1 held 4 cycles, PCin high only in the final one; IRin 1 cycle later.
//  3. MUL: LOin in T5 then HIin in T6, alu_op=00111 in T4 only; back to T0 on cycle 8.
//  4. LD with mem_ready never asserted in T6: HLT after TIMEOUT=15 stall cycles, error=1, run=0, all strobes 0.
//  5. Reset pulled low during ST T6: outputs 0 asynchronously; after release, T0 with PCout=1 one clock later, error=0.
//  6. Opcode 11111 executes as NOP (T3 -> T0, no strobes). HALT 11011: run falls after T3 and stays 0 over 20 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer.
//   - opcode values carried in the top five bits of the instruction register
//   - sequencer state encoding (RST, T0..T7, HLT in 4 bits)
//   - opcode classes and the classify() helper used by both the state logic and
//     the strobe decoder, so the two always agree on what an opcode means
//   - ctl_t: the full strobe vector handed from the decoder to the top
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_ADDI = 5'b00100;
  localparam logic [4:0] OP_ANDI = 5'b00101;
  localparam logic [4:0] OP_ORI  = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b00111;
  localparam logic [4:0] OP_DIV  = 5'b01000;
  localparam logic [4:0] OP_LD   = 5'b01001;
  localparam logic [4:0] OP_ST   = 5'b01010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU opcode driven whenever no ALU operation is requested, and used for
  // the effective-address add of LD/ST.
  localparam logic [4:0] ALU_ADD = 5'b00000;

  typedef enum logic [3:0] {
    ST_RST = 4'd0,
    ST_T0  = 4'd1,
    ST_T1  = 4'd2,
    ST_T2  = 4'd3,
    ST_T3  = 4'd4,
    ST_T4  = 4'd5,
    ST_T5  = 4'd6,
    ST_T6  = 4'd7,
    ST_T7  = 4'd8,
    ST_HLT = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_IMM    = 3'd2,
    CLS_MULDIV = 3'd3,
    CLS_LD     = 3'd4,
    CLS_ST     = 3'd5,
    CLS_HALT   = 3'd6
  } op_class_t;

  typedef struct packed {
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       baout;
    logic       pcout;
    logic       pcin;
    logic       incpc;
    logic       marin;
    logic       mdrin;
    logic       mdrout;
    logic       irin;
    logic       yin;
    logic       zin;
    logic       zlowout;
    logic       zhighout;
    logic       hiin;
    logic       loin;
    logic       cout;
    logic       read;
    logic       mem_write;
    logic       run;
    logic [4:0] alu_op;
  } ctl_t;

  // Unknown opcodes fall into CLS_NOP so they execute as a one-step no-op.
  function automatic op_class_t classify(input logic [4:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:      cls = CLS_IMM;
      OP_MUL, OP_DIV:                cls = CLS_MULDIV;
      OP_LD:                         cls = CLS_LD;
      OP_ST:                         cls = CLS_ST;
      OP_HALT:                       cls = CLS_HALT;
      default:                       cls = CLS_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// Combinational strobe decoder: {state, opcode} -> strobe vector.
// Ports:
//   state      in   current sequencer state
//   opcode     in   ir[IR_W-1 -: 5]
//   mem_ready  in   only used to gate PCin to the exit cycle of T1
//   ctl        out  every DataPath strobe plus alu_op and run
module ctl_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       mem_ready,
  output ctl_t       ctl
);

  op_class_t cls;
  assign cls = classify(opcode);

  always_comb begin
    ctl     = '0;
    ctl.run = (state != ST_RST) && (state != ST_HLT);
    case (state)
      ST_T0: begin
        ctl.pcout = 1'b1;
        ctl.marin = 1'b1;
        ctl.incpc = 1'b1;
        ctl.zin   = 1'b1;
      end
      ST_T1: begin
        ctl.zlowout = 1'b1;
        ctl.read    = 1'b1;
        ctl.mdrin   = 1'b1;
        // PC only reloads in the cycle the fetch completes, so a stalled
        // fetch does not repeatedly rewrite it.
        ctl.pcin    = mem_ready;
      end
      ST_T2: begin
        ctl.mdrout = 1'b1;
        ctl.irin   = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CLS_ALU, CLS_IMM: begin
            ctl.grb  = 1'b1;
            ctl.rout = 1'b1;
            ctl.yin  = 1'b1;
          end
          CLS_MULDIV: begin
            ctl.gra  = 1'b1;
            ctl.rout = 1'b1;
            ctl.yin  = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctl.grb   = 1'b1;
            ctl.baout = 1'b1;
            ctl.yin   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_ALU: begin
            ctl.grc    = 1'b1;
            ctl.rout   = 1'b1;
            ctl.zin    = 1'b1;
            ctl.alu_op = opcode;
          end
          CLS_IMM: begin
            ctl.cout   = 1'b1;
            ctl.zin    = 1'b1;
            ctl.alu_op = opcode;
          end
          CLS_MULDIV: begin
            ctl.grb    = 1'b1;
            ctl.rout   = 1'b1;
            ctl.zin    = 1'b1;
            ctl.alu_op = opcode;
          end
          CLS_LD, CLS_ST: begin
            ctl.cout   = 1'b1;
            ctl.zin    = 1'b1;
            ctl.alu_op = ALU_ADD;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_ALU, CLS_IMM: begin
            ctl.zlowout = 1'b1;
            ctl.gra     = 1'b1;
            ctl.rin     = 1'b1;
          end
          CLS_MULDIV: begin
            ctl.zlowout = 1'b1;
            ctl.loin    = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctl.zlowout = 1'b1;
            ctl.marin   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CLS_MULDIV: begin
            ctl.zhighout = 1'b1;
            ctl.hiin     = 1'b1;
          end
          CLS_LD: begin
            ctl.read  = 1'b1;
            ctl.mdrin = 1'b1;
          end
          CLS_ST: begin
            ctl.gra   = 1'b1;
            ctl.rout  = 1'b1;
            ctl.mdrin = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CLS_LD: begin
            ctl.mdrout = 1'b1;
            ctl.gra    = 1'b1;
            ctl.rin    = 1'b1;
          end
          CLS_ST: ctl.mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the DataPath: fetch (T0-T2), per-opcode execute
// (T3-T7), memory wait states with a stall timeout that halts the CPU.
// Ports:
//   clock      in   rising-edge clock
//   clear      in   asynchronous active-low reset
//   ir         in   instruction register, opcode in the top five bits
//   mem_ready  in   memory read data valid / write accepted
//   Gra..Cout  out  DataPath strobes
//   read       out  memory read request
//   mem_write  out  memory write strobe
//   alu_op     out  ALU opcode (ADD when idle)
//   run        out  high while sequencing, low in RST/HLT
//   error      out  sticky memory-timeout flag
//   state_dbg  out  current state encoding for observation
//
// Memory handshake: in a wait state (T1, LD-T6, ST-T7) the request strobes
// stay asserted and the step completes on the first rising edge where
// mem_ready=1. Each edge with mem_ready=0 counts one stall; once TIMEOUT
// stalls have accumulated, a further edge with mem_ready=0 halts with error,
// while mem_ready=1 on that edge still completes the step normally.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int IR_W    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            mem_ready,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIin,
  output logic            LOin,
  output logic            Cout,
  output logic            read,
  output logic            mem_write,
  output logic [4:0]      alu_op,
  output logic            run,
  output logic            error,
  output logic [3:0]      state_dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t    state, state_nxt, follow;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic      error_nxt;
  logic      in_wait;
  logic [4:0] opcode;
  op_class_t cls;
  ctl_t      ctl;
  logic      ir_unused;

  assign opcode    = ir[IR_W-1 -: 5];
  assign ir_unused = ^ir[IR_W-6:0];
  assign cls       = classify(opcode);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= ST_RST;
      wait_cnt <= '0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      error    <= error_nxt;
    end
  end

  always_comb begin
    follow       = state;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    error_nxt    = error;
    in_wait      = (state == ST_T1) ||
                   ((state == ST_T6) && (cls == CLS_LD)) ||
                   ((state == ST_T7) && (cls == CLS_ST));

    // Where the current step goes once it is allowed to complete.
    case (state)
      ST_RST: follow = ST_T0;
      ST_T0:  follow = ST_T1;
      ST_T1:  follow = ST_T2;
      ST_T2:  follow = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_NOP:  follow = ST_T0;
          CLS_HALT: follow = ST_HLT;
          default:  follow = ST_T4;
        endcase
      end
      ST_T4:  follow = ST_T5;
      ST_T5:  follow = ((cls == CLS_ALU) || (cls == CLS_IMM)) ? ST_T0 : ST_T6;
      ST_T6:  follow = (cls == CLS_MULDIV) ? ST_T0 : ST_T7;
      ST_T7:  follow = ST_T0;
      ST_HLT: follow = ST_HLT;
      default: follow = ST_RST;
    endcase

    if (in_wait && !mem_ready) begin
      if (wait_cnt == CW'(TIMEOUT)) begin
        state_nxt    = ST_HLT;
        error_nxt    = 1'b1;
        wait_cnt_nxt = '0;
      end else begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt + 1'b1;
      end
    end else begin
      state_nxt    = follow;
      wait_cnt_nxt = '0;
    end
  end

  ctl_decode u_decode (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctl       (ctl)
  );

  assign Gra       = ctl.gra;
  assign Grb       = ctl.grb;
  assign Grc       = ctl.grc;
  assign Rin       = ctl.rin;
  assign Rout      = ctl.rout;
  assign BAout     = ctl.baout;
  assign PCout     = ctl.pcout;
  assign PCin      = ctl.pcin;
  assign IncPC     = ctl.incpc;
  assign MARin     = ctl.marin;
  assign MDRin     = ctl.mdrin;
  assign MDRout    = ctl.mdrout;
  assign IRin      = ctl.irin;
  assign Yin       = ctl.yin;
  assign Zin       = ctl.zin;
  assign Zlowout   = ctl.zlowout;
  assign Zhighout  = ctl.zhighout;
  assign HIin      = ctl.hiin;
  assign LOin      = ctl.loin;
  assign Cout      = ctl.cout;
  assign read      = ctl.read;
  assign mem_write = ctl.mem_write;
  assign alu_op    = ctl.alu_op;
  assign run       = ctl.run;
  assign state_dbg = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. Each instruction is expanded into a list of
// micro-steps taken straight from the control table (strobe set, alu_op,
// whether the step waits on memory); the driver walks that list one clock at
// a time, inserting stall cycles on wait steps, and compares all outputs.
module tb_control_sequencer;

  localparam int TIMEOUT = 15;

  // Bench-side bit layout of the observed strobe vector.
  localparam logic [23:0] M_GRA   = 24'd1 << 23;
  localparam logic [23:0] M_GRB   = 24'd1 << 22;
  localparam logic [23:0] M_GRC   = 24'd1 << 21;
  localparam logic [23:0] M_RIN   = 24'd1 << 20;
  localparam logic [23:0] M_ROUT  = 24'd1 << 19;
  localparam logic [23:0] M_BAOUT = 24'd1 << 18;
  localparam logic [23:0] M_PCOUT = 24'd1 << 17;
  localparam logic [23:0] M_PCIN  = 24'd1 << 16;
  localparam logic [23:0] M_INCPC = 24'd1 << 15;
  localparam logic [23:0] M_MARIN = 24'd1 << 14;
  localparam logic [23:0] M_MDRIN = 24'd1 << 13;
  localparam logic [23:0] M_MDROUT= 24'd1 << 12;
  localparam logic [23:0] M_IRIN  = 24'd1 << 11;
  localparam logic [23:0] M_YIN   = 24'd1 << 10;
  localparam logic [23:0] M_ZIN   = 24'd1 << 9;
  localparam logic [23:0] M_ZLO   = 24'd1 << 8;
  localparam logic [23:0] M_ZHI   = 24'd1 << 7;
  localparam logic [23:0] M_HIIN  = 24'd1 << 6;
  localparam logic [23:0] M_LOIN  = 24'd1 << 5;
  localparam logic [23:0] M_COUT  = 24'd1 << 4;
  localparam logic [23:0] M_READ  = 24'd1 << 3;
  localparam logic [23:0] M_MEMW  = 24'd1 << 2;
  localparam logic [23:0] M_RUN   = 24'd1 << 1;
  localparam logic [23:0] M_ERR   = 24'd1 << 0;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin;
  logic MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout;
  logic read, mem_write, run, error;
  logic [4:0] alu_op;
  logic [3:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [23:0] v;
    logic [4:0]  alu;
    bit          wt;
    logic [23:0] exit_v;
  } ustep_t;

  ustep_t      plan[$];
  bit          plan_halts;
  logic [31:0] pending_ir;
  bit          ir_load = 0;

  control_sequencer #(.IR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Cout(Cout), .read(read),
    .mem_write(mem_write), .alu_op(alu_op), .run(run), .error(error),
    .state_dbg(state_dbg)
  );

  // Clock / reset block: reset is driven by the sequence below.
  always #5 clock = ~clock;

  // ---------------- reference model: micro-step plan ----------------
  function automatic void add(input string t, input logic [23:0] v, input logic [4:0] a,
                              input bit w, input logic [23:0] xv);
    ustep_t s;
    s.tag = t; s.v = v | M_RUN; s.alu = a; s.wt = w; s.exit_v = xv;
    plan.push_back(s);
  endfunction

  function automatic void build_plan(input logic [4:0] op);
    plan.delete();
    plan_halts = 0;
    add("T0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 0, '0);
    add("T1", M_ZLO | M_READ | M_MDRIN, 5'd0, 1, M_PCIN);
    add("T2", M_MDROUT | M_IRIN, 5'd0, 0, '0);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011: begin
        add("R_T3", M_GRB | M_ROUT | M_YIN, 5'd0, 0, '0);
        add("R_T4", M_GRC | M_ROUT | M_ZIN, op, 0, '0);
        add("R_T5", M_ZLO | M_GRA | M_RIN, 5'd0, 0, '0);
      end
      5'b00100, 5'b00101, 5'b00110: begin
        add("I_T3", M_GRB | M_ROUT | M_YIN, 5'd0, 0, '0);
        add("I_T4", M_COUT | M_ZIN, op, 0, '0);
        add("I_T5", M_ZLO | M_GRA | M_RIN, 5'd0, 0, '0);
      end
      5'b00111, 5'b01000: begin
        add("MD_T3", M_GRA | M_ROUT | M_YIN, 5'd0, 0, '0);
        add("MD_T4", M_GRB | M_ROUT | M_ZIN, op, 0, '0);
        add("MD_T5", M_ZLO | M_LOIN, 5'd0, 0, '0);
        add("MD_T6", M_ZHI | M_HIIN, 5'd0, 0, '0);
      end
      5'b01001: begin
        add("LD_T3", M_GRB | M_BAOUT | M_YIN, 5'd0, 0, '0);
        add("LD_T4", M_COUT | M_ZIN, 5'd0, 0, '0);
        add("LD_T5", M_ZLO | M_MARIN, 5'd0, 0, '0);
        add("LD_T6", M_READ | M_MDRIN, 5'd0, 1, '0);
        add("LD_T7", M_MDROUT | M_GRA | M_RIN, 5'd0, 0, '0);
      end
      5'b01010: begin
        add("ST_T3", M_GRB | M_BAOUT | M_YIN, 5'd0, 0, '0);
        add("ST_T4", M_COUT | M_ZIN, 5'd0, 0, '0);
        add("ST_T5", M_ZLO | M_MARIN, 5'd0, 0, '0);
        add("ST_T6", M_GRA | M_ROUT | M_MDRIN, 5'd0, 0, '0);
        add("ST_T7", M_MEMW, 5'd0, 1, '0);
      end
      5'b11011: begin
        add("HALT_T3", '0, 5'd0, 0, '0);
        plan_halts = 1;
      end
      default: add("NOP_T3", '0, 5'd0, 0, '0);
    endcase
  endfunction

  // ---------------- scoreboard / comparison ----------------
  task automatic check_now(input string tag, input logic [23:0] ev, input logic [4:0] ea);
    logic [28:0] obs;
    logic [28:0] exp;
    obs = {alu_op, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin,
           MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout,
           read, mem_write, run, error};
    exp = {ea, ev};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed alu=%b strobes=%h, expected alu=%b strobes=%h",
             tag, obs[28:24], obs[23:0], ea, ev);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input string tag, input logic rdy, input logic [23:0] ev,
                       input logic [4:0] ea);
    @(negedge clock);
    if (ir_load) begin
      ir = pending_ir;
      ir_load = 0;
    end
    mem_ready = rdy;
    #1;
    check_now(tag, ev, ea);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 clear = 1'b0;
    #1 check_now("reset_async", '0, 5'd0);
    @(negedge clock);
    clear = 1'b1;
  endtask

  // Runs one instruction from T0. status=1 means the sequencer ended in HLT.
  task automatic run_instr(input logic [4:0] op, input int fetch_stall,
                           input int mem_stall, input int abort_at, output bit status);
    int s;
    status = 0;
    build_plan(op);
    pending_ir = {op, 27'($urandom)};
    ir_load = 1;
    for (int i = 0; i < plan.size(); i++) begin
      if (plan[i].wt) begin
        s = (i == 1) ? fetch_stall : mem_stall;
        for (int k = 0; k < s && k <= TIMEOUT; k++)
          cycle(plan[i].tag, 1'b0, plan[i].v, plan[i].alu);
        if (s > TIMEOUT) begin
          cycle("timeout_hlt", 1'($urandom_range(0, 1)), M_ERR, 5'd0);
          cycle("timeout_hlt_hold", 1'($urandom_range(0, 1)), M_ERR, 5'd0);
          status = 1;
          return;
        end
        cycle(plan[i].tag, 1'b1, plan[i].v | plan[i].exit_v, plan[i].alu);
      end else begin
        cycle(plan[i].tag, 1'($urandom_range(0, 1)), plan[i].v, plan[i].alu);
      end
      if (i == abort_at) begin
        #1 clear = 1'b0;
        #1 check_now("abort_async_zero", '0, 5'd0);
        @(negedge clock);
        #1 check_now("abort_held", '0, 5'd0);
        clear = 1'b1;
        return;
      end
    end
    if (plan_halts) begin
      for (int k = 0; k < 20; k++)
        cycle("halt_idle", 1'($urandom_range(0, 1)), '0, 5'd0);
      status = 1;
    end
  endtask

  function automatic int pick_stall();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 18) return $urandom_range(1, 4);
    if (r == 18) return TIMEOUT;
    return TIMEOUT + 1;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    bit st;
    logic [4:0] ops [15];
    logic [4:0] op;
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b11010, 5'b11011, 5'b11111,
            5'b10101};

    #1 check_now("reset_state", '0, 5'd0);
    @(negedge clock);
    clear = 1'b1;

    run_instr(5'b00110, 0, 0, -1, st);            // ORI, mem_ready high
    run_instr(5'b00000, 3, 0, -1, st);            // ADD, fetch stalled 3 cycles
    run_instr(5'b00111, 0, 0, -1, st);            // MUL
    run_instr(5'b01000, 1, 0, -1, st);            // DIV
    run_instr(5'b01001, 0, 2, -1, st);            // LD, short memory wait
    run_instr(5'b01010, 0, TIMEOUT, -1, st);      // ST, ready at the timeout edge
    run_instr(5'b00001, TIMEOUT, 0, -1, st);      // SUB, fetch ready at the timeout edge
    run_instr(5'b11111, 0, 0, -1, st);            // unknown opcode runs as NOP
    run_instr(5'b11010, 0, 0, -1, st);            // NOP
    run_instr(5'b01001, 0, TIMEOUT + 1, -1, st);  // LD never ready -> error halt
    do_reset();
    run_instr(5'b01010, 0, 0, 6, st);             // ST aborted by reset in T6
    run_instr(5'b00101, 0, 0, -1, st);            // ANDI after the abort, error clear
    run_instr(5'b00010, TIMEOUT + 1, 0, -1, st);  // fetch timeout
    do_reset();
    run_instr(5'b11011, 0, 0, -1, st);            // HALT then 20 idle cycles
    do_reset();

    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 14)];
      run_instr(op, pick_stall(), pick_stall(), -1, st);
      if (st) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
